// File: rtl/rsa_bridge_pkg.sv
// Shared types and constants for the RSA-256 Avalon UART bridge.
// Holds the top/transfer state enums, byte counts and default UART addresses.
package rsa_bridge_pkg;

    typedef enum logic [1:0] {
        S_GET_KEY,
        S_GET_DATA,
        S_WAIT_CALC,
        S_SEND_DATA
    } top_state_t;

    typedef enum logic {
        X_POLL,
        X_DATA
    } xfer_state_t;

    localparam int KEY_BYTES  = 64;
    localparam int DATA_BYTES = 32;
    localparam int OUT_BYTES  = 31;

    localparam logic [4:0] DEF_RX_BASE     = 5'd0;
    localparam logic [4:0] DEF_TX_BASE     = 5'd4;
    localparam logic [4:0] DEF_STATUS_BASE = 5'd8;
    localparam int         DEF_RX_OK_BIT   = 7;
    localparam int         DEF_TX_OK_BIT   = 6;

endpackage

// File: rtl/avm_byte_xfer.sv
// One-byte UART transfer engine: polls status, then reads RX or writes TX.
// Ports: i_go/i_dir/i_wbyte request, o_rbyte/o_done result, avm_* master.
module avm_byte_xfer
    import rsa_bridge_pkg::*;
#(
    parameter logic [4:0] RX_BASE     = DEF_RX_BASE,
    parameter logic [4:0] TX_BASE     = DEF_TX_BASE,
    parameter logic [4:0] STATUS_BASE = DEF_STATUS_BASE,
    parameter int         RX_OK_BIT   = DEF_RX_OK_BIT,
    parameter int         TX_OK_BIT   = DEF_TX_OK_BIT
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_go,
    input  logic        i_dir,
    input  logic [7:0]  i_wbyte,
    output logic [7:0]  o_rbyte,
    output logic        o_done,
    output logic [4:0]  avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    input  logic        avm_waitrequest
);

    xfer_state_t r_state, w_state_nxt;
    logic        r_read, w_read_nxt;
    logic        r_write, w_write_nxt;
    logic [4:0]  r_addr, w_addr_nxt;
    logic [7:0]  r_wbyte, w_wbyte_nxt;
    logic        w_ack;
    logic        w_ok;
    logic        w_unused;

    assign w_ack    = (r_read | r_write) & ~avm_waitrequest;
    assign w_ok     = i_dir ? avm_readdata[TX_OK_BIT]
                            : avm_readdata[RX_OK_BIT];
    assign o_done   = w_ack & (r_state == X_DATA);
    assign o_rbyte  = avm_readdata[7:0];
    assign w_unused = ^avm_readdata;

    assign avm_address   = r_addr;
    assign avm_read      = r_read;
    assign avm_write     = r_write;
    assign avm_writedata = {24'd0, r_wbyte};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= X_POLL;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_addr  <= STATUS_BASE;
            r_wbyte <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_read  <= w_read_nxt;
            r_write <= w_write_nxt;
            r_addr  <= w_addr_nxt;
            r_wbyte <= w_wbyte_nxt;
        end
    end

    // Requests are registered; the follow-up request is chosen in the
    // completion cycle so back-to-back accesses cost one cycle each.
    always_comb begin
        w_state_nxt = r_state;
        w_read_nxt  = r_read;
        w_write_nxt = r_write;
        w_addr_nxt  = r_addr;
        w_wbyte_nxt = r_wbyte;
        if (!(r_read | r_write)) begin
            if (i_go) begin
                w_state_nxt = X_POLL;
                w_read_nxt  = 1'b1;
                w_addr_nxt  = STATUS_BASE;
            end
        end else if (w_ack) begin
            unique case (r_state)
                X_POLL: begin
                    if (w_ok) begin
                        w_state_nxt = X_DATA;
                        w_read_nxt  = ~i_dir;
                        w_write_nxt = i_dir;
                        w_addr_nxt  = i_dir ? TX_BASE : RX_BASE;
                        w_wbyte_nxt = i_dir ? i_wbyte : 8'd0;
                    end
                end
                X_DATA: begin
                    w_state_nxt = X_POLL;
                    w_read_nxt  = i_go;
                    w_write_nxt = 1'b0;
                    w_addr_nxt  = STATUS_BASE;
                    w_wbyte_nxt = 8'd0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/rsa256_avalon_bridge.sv
// RSA-256 front end: loads n/d/a from the UART, starts the core, returns 31 bytes.
// Ports: i_clk/i_rst, avm_* UART master, o_rsa_* core controls, i_rsa_* core result.
module rsa256_avalon_bridge
    import rsa_bridge_pkg::*;
#(
    parameter logic [4:0] RX_BASE     = DEF_RX_BASE,
    parameter logic [4:0] TX_BASE     = DEF_TX_BASE,
    parameter logic [4:0] STATUS_BASE = DEF_STATUS_BASE,
    parameter int         RX_OK_BIT   = DEF_RX_OK_BIT,
    parameter int         TX_OK_BIT   = DEF_TX_OK_BIT
) (
    input  logic         i_clk,
    input  logic         i_rst,
    output logic [4:0]   avm_address,
    output logic         avm_read,
    input  logic [31:0]  avm_readdata,
    output logic         avm_write,
    output logic [31:0]  avm_writedata,
    input  logic         avm_waitrequest,
    output logic         o_rsa_start,
    output logic [255:0] o_rsa_a,
    output logic [255:0] o_rsa_d,
    output logic [255:0] o_rsa_n,
    input  logic         i_rsa_finished,
    input  logic [255:0] i_rsa_result
);

    top_state_t   r_state, w_state_nxt;
    logic [5:0]   r_cnt, w_cnt_nxt;
    logic [255:0] r_n, w_n_nxt;
    logic [255:0] r_d, w_d_nxt;
    logic [255:0] r_a, w_a_nxt;
    logic [247:0] r_res, w_res_nxt;
    logic         r_start, w_start_nxt;
    logic         w_go, w_dir, w_done, w_last;
    logic [7:0]   w_rbyte;
    logic         w_unused_res;

    assign o_rsa_start  = r_start;
    assign o_rsa_a      = r_a;
    assign o_rsa_d      = r_d;
    assign o_rsa_n      = r_n;
    assign w_unused_res = ^i_rsa_result[255:248];

    // Drop the request stream on the last ciphertext byte so no status
    // poll is left in flight while the core runs.
    assign w_last = (r_state == S_GET_DATA) & w_done
                  & (r_cnt == 6'(DATA_BYTES - 1));
    assign w_go   = (r_state != S_WAIT_CALC) & ~w_last;
    assign w_dir  = (r_state == S_SEND_DATA);

    avm_byte_xfer #(
        .RX_BASE     (RX_BASE),
        .TX_BASE     (TX_BASE),
        .STATUS_BASE (STATUS_BASE),
        .RX_OK_BIT   (RX_OK_BIT),
        .TX_OK_BIT   (TX_OK_BIT)
    ) u_xfer (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_go            (w_go),
        .i_dir           (w_dir),
        .i_wbyte         (r_res[247:240]),
        .o_rbyte         (w_rbyte),
        .o_done          (w_done),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_readdata    (avm_readdata),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_waitrequest (avm_waitrequest)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_GET_KEY;
            r_cnt   <= 6'd0;
            r_n     <= '0;
            r_d     <= '0;
            r_a     <= '0;
            r_res   <= '0;
            r_start <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_n     <= w_n_nxt;
            r_d     <= w_d_nxt;
            r_a     <= w_a_nxt;
            r_res   <= w_res_nxt;
            r_start <= w_start_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_n_nxt     = r_n;
        w_d_nxt     = r_d;
        w_a_nxt     = r_a;
        w_res_nxt   = r_res;
        w_start_nxt = 1'b0;
        unique case (r_state)
            S_GET_KEY: begin
                if (w_done) begin
                    if (r_cnt < 6'(KEY_BYTES / 2)) begin
                        w_n_nxt = {r_n[247:0], w_rbyte};
                    end else begin
                        w_d_nxt = {r_d[247:0], w_rbyte};
                    end
                    if (r_cnt == 6'(KEY_BYTES - 1)) begin
                        w_cnt_nxt   = 6'd0;
                        w_state_nxt = S_GET_DATA;
                    end else begin
                        w_cnt_nxt = r_cnt + 6'd1;
                    end
                end
            end
            S_GET_DATA: begin
                if (w_done) begin
                    w_a_nxt = {r_a[247:0], w_rbyte};
                    if (w_last) begin
                        w_cnt_nxt   = 6'd0;
                        w_start_nxt = 1'b1;
                        w_state_nxt = S_WAIT_CALC;
                    end else begin
                        w_cnt_nxt = r_cnt + 6'd1;
                    end
                end
            end
            S_WAIT_CALC: begin
                if (i_rsa_finished) begin
                    w_res_nxt   = i_rsa_result[247:0];
                    w_state_nxt = S_SEND_DATA;
                end
            end
            S_SEND_DATA: begin
                if (w_done) begin
                    w_res_nxt = {r_res[239:0], 8'h00};
                    if (r_cnt == 6'(OUT_BYTES - 1)) begin
                        w_cnt_nxt   = 6'd0;
                        w_state_nxt = S_GET_DATA;
                    end else begin
                        w_cnt_nxt = r_cnt + 6'd1;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rsa256_avalon_bridge.sv
// Self-checking bench for rsa256_avalon_bridge with a UART slave and core model.
// Ports: none; drives the bridge through directed block vectors and corner sequences.
module tb_rsa256_avalon_bridge;

    logic         clk = 1'b0;
    logic         rst;
    logic [4:0]   avm_address;
    logic         avm_read;
    logic [31:0]  avm_readdata;
    logic         avm_write;
    logic [31:0]  avm_writedata;
    logic         avm_waitrequest;
    logic         o_rsa_start;
    logic [255:0] o_rsa_a, o_rsa_d, o_rsa_n;
    logic         i_rsa_finished = 1'b0;
    logic [255:0] i_rsa_result = '0;

    always #5 clk = ~clk;

    rsa256_avalon_bridge dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_readdata    (avm_readdata),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_waitrequest (avm_waitrequest),
        .o_rsa_start     (o_rsa_start),
        .o_rsa_a         (o_rsa_a),
        .o_rsa_d         (o_rsa_d),
        .o_rsa_n         (o_rsa_n),
        .i_rsa_finished  (i_rsa_finished),
        .i_rsa_result    (i_rsa_result)
    );

    localparam logic [255:0] EXP_N =
        256'h0102030405060708_090A0B0C0D0E0F10_1112131415161718_191A1B1C1D1E1F20;
    localparam logic [255:0] EXP_D =
        256'h2122232425262728_292A2B2C2D2E2F30_3132333435363738_393A3B3C3D3E3F40;

    // UART slave model
    logic [7:0]   rx_mem [0:511];
    logic [7:0]   tx_mem [0:511];
    int           rx_wr = 0, rx_rd = 0, hold_until = 0;
    int           status_reads = 0, data_reads = 0, held_polls = 0;
    int           tx_cnt = 0, tx_bad = 0;
    int           cyc = 0, last_rx_cyc = 0, start_cyc = 0;
    int           start_count = 0, reads_at_start = 0, core_cnt = 0;
    int           stall_viol = 0, stall_events = 0;
    logic [255:0] core_res = '0;
    bit           wait_en = 1'b0, force_wait = 1'b0, rand_wait = 1'b0;
    bit           stall_q = 1'b0;
    logic [69:0]  stall_sig = '0;
    logic         rx_ok;

    assign rx_ok = (rx_rd < rx_wr) && (status_reads >= hold_until);
    assign avm_waitrequest = force_wait | rand_wait;
    assign avm_readdata =
        (avm_address == 5'd8) ? {24'd0, rx_ok, 1'b1, 6'd0} :
        (avm_address == 5'd0) ? {24'h5A5A5A, rx_mem[rx_rd]} : 32'hDEAD_BEEF;

    always @(negedge clk) rand_wait <= wait_en ? 1'($urandom_range(0, 1)) : 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (avm_read && !avm_waitrequest) begin
            if (avm_address == 5'd8) begin
                status_reads <= status_reads + 1;
                if (rx_rd < rx_wr && status_reads < hold_until)
                    held_polls <= held_polls + 1;
            end else if (avm_address == 5'd0) begin
                rx_rd       <= rx_rd + 1;
                data_reads  <= data_reads + 1;
                last_rx_cyc <= cyc;
            end
        end
        if (avm_write && !avm_waitrequest) begin
            tx_mem[tx_cnt] <= avm_writedata[7:0];
            tx_cnt         <= tx_cnt + 1;
            if (avm_writedata[31:8] != 24'd0 || avm_address != 5'd4)
                tx_bad <= tx_bad + 1;
        end
        if (o_rsa_start) begin
            start_count    <= start_count + 1;
            start_cyc      <= cyc;
            reads_at_start <= data_reads;
            core_cnt       <= 10;
        end else if (core_cnt > 0) begin
            core_cnt <= core_cnt - 1;
        end
        i_rsa_finished <= (core_cnt == 1) && !o_rsa_start;
        i_rsa_result   <= core_res;
        if (stall_q && {avm_address, avm_read, avm_write, avm_writedata} != stall_sig)
            stall_viol <= stall_viol + 1;
        stall_q   <= (avm_read || avm_write) && avm_waitrequest && !rst;
        stall_sig <= {avm_address, avm_read, avm_write, avm_writedata};
        if ((avm_read || avm_write) && avm_waitrequest)
            stall_events <= stall_events + 1;
    end

    int tests = 0, fails = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        rx_mem[rx_wr] = b;
        rx_wr++;
    endtask

    typedef struct {
        string        name;
        bit           wait_en;
        int           hold;
        logic [7:0]   first;
        logic [255:0] exp_a;
        logic [255:0] res;
    } vec_t;

    vec_t         vecs [3];
    int           sc0, dr0, hp0, tx0;
    logic [247:0] got;

    initial begin
        vecs[0] = '{"zero_wait", 1'b0, 0, 8'hA0,
            256'hA0A1A2A3A4A5A6A7_A8A9AAABACADAEAF_B0B1B2B3B4B5B6B7_B8B9BABBBCBDBEBF,
            256'h00FFEEDDCCBBAA99_8877665544332211_00FFEEDDCCBBAA99_8877665544332211};
        vecs[1] = '{"wait_stress", 1'b1, 0, 8'hA0,
            256'hA0A1A2A3A4A5A6A7_A8A9AAABACADAEAF_B0B1B2B3B4B5B6B7_B8B9BABBBCBDBEBF,
            256'hAB0123456789ABCD_EF0123456789ABCD_EF0123456789ABCD_EF0123456789ABCD};
        vecs[2] = '{"rx_hold", 1'b0, 5, 8'h00,
            256'h0001020304050607_08090A0B0C0D0E0F_1011121314151617_18191A1B1C1D1E1F,
            256'h5500112233445566_778899AABBCCDDEE_FF00112233445566_778899AABBCCDDEE};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_read", avm_read, 0);
        chk("rst_write", avm_write, 0);
        chk("rst_addr", avm_address, 8);
        chk("rst_wdata", avm_writedata, 0);
        chk("rst_start", o_rsa_start, 0);
        chk("rst_nda", {o_rsa_n | o_rsa_d | o_rsa_a}, 0);

        for (int i = 1; i <= 64; i++) push(8'(i));
        rst = 1'b0;
        for (int k = 0; k < 2000 && data_reads < 64; k++) @(negedge clk);
        repeat (5) @(negedge clk);
        chk("key_reads", data_reads, 64);
        chk("key_n", o_rsa_n, EXP_N);
        chk("key_d", o_rsa_d, EXP_D);
        chk("key_no_start", start_count, 0);

        for (int v = 0; v < 3; v++) begin
            sc0 = start_count; dr0 = data_reads;
            hp0 = held_polls;  tx0 = tx_cnt;
            wait_en    = vecs[v].wait_en;
            core_res   = vecs[v].res;
            hold_until = status_reads + vecs[v].hold;
            for (int k = 0; k < 32; k++) push(8'(vecs[v].first + 8'(k)));
            for (int k = 0; k < 3000 && start_count == sc0; k++) @(negedge clk);
            chk({vecs[v].name, "_start"}, start_count - sc0, 1);
            chk({vecs[v].name, "_a"}, o_rsa_a, vecs[v].exp_a);
            chk({vecs[v].name, "_n"}, o_rsa_n, EXP_N);
            chk({vecs[v].name, "_d"}, o_rsa_d, EXP_D);
            chk({vecs[v].name, "_rx_bytes"}, reads_at_start - dr0, 32);
            chk({vecs[v].name, "_held"}, held_polls - hp0, vecs[v].hold);
            chk({vecs[v].name, "_start_lat"}, start_cyc - last_rx_cyc, 1);
            for (int k = 0; k < 3000 && tx_cnt < tx0 + 31; k++) @(negedge clk);
            repeat (30) @(negedge clk);
            chk({vecs[v].name, "_tx_count"}, tx_cnt - tx0, 31);
            chk({vecs[v].name, "_one_start"}, start_count - sc0, 1);
            for (int j = 0; j < 31; j++) got[247 - 8 * j -: 8] = tx_mem[tx0 + j];
            chk({vecs[v].name, "_tx_bytes"}, got, vecs[v].res[247:0]);
        end
        wait_en = 1'b0;
        chk("tx_upper_zero", tx_bad, 0);
        chk("stall_stable", stall_viol, 0);
        chk("stall_seen", stall_events > 20, 1);

        // reset while a TX write is stalled
        tx0 = tx_cnt;
        core_res = vecs[0].res;
        hold_until = status_reads;
        for (int k = 0; k < 32; k++) push(8'(8'hA0 + 8'(k)));
        for (int k = 0; k < 3000 && tx_cnt < tx0 + 5; k++) @(negedge clk);
        for (int k = 0; k < 50 && !avm_write; k++) @(negedge clk);
        chk("mid_write_seen", avm_write, 1);
        force_wait = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_write", avm_write, 0);
        chk("mid_rst_read", avm_read, 0);
        chk("mid_rst_addr", avm_address, 8);
        chk("mid_rst_regs", {o_rsa_n | o_rsa_d | o_rsa_a}, 0);
        force_wait = 1'b0;
        rst = 1'b0;

        sc0 = start_count; dr0 = data_reads; tx0 = tx_cnt;
        core_res = vecs[2].res;
        for (int i = 1; i <= 64; i++) push(8'(i));
        for (int k = 0; k < 32; k++) push(8'(k));
        for (int k = 0; k < 5000 && start_count == sc0; k++) @(negedge clk);
        chk("reload_start", start_count - sc0, 1);
        chk("reload_rx_bytes", reads_at_start - dr0, 96);
        chk("reload_n", o_rsa_n, EXP_N);
        chk("reload_d", o_rsa_d, EXP_D);
        chk("reload_a", o_rsa_a, vecs[2].exp_a);
        for (int k = 0; k < 3000 && tx_cnt < tx0 + 31; k++) @(negedge clk);
        repeat (10) @(negedge clk);
        chk("reload_tx_count", tx_cnt - tx0, 31);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
